// File: rtl/b_resp_gen.sv
// b_resp_gen: AXI slave write-response generator pairing AW entries with W-last entries into a registered B channel.
// Optional B_DECERR_EN adds aw_decerr, stored per AW entry, giving BRESP=DECERR with priority over SLVERR.
module b_resp_gen #(
  parameter int ID_WIDTH = 4,
  parameter int DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      aw_push,
  input  logic [ID_WIDTH-1:0]       aw_id,
  input  logic                      aw_slverr,
`ifdef B_DECERR_EN
  input  logic                      aw_decerr,
`endif
  output logic                      aw_full,
  input  logic                      w_push,
  input  logic                      w_slverr,
  output logic                      w_full,
  output logic                      BVALID,
  input  logic                      BREADY,
  output logic [ID_WIDTH-1:0]       BID,
  output logic [1:0]                BRESP,
  output logic [$clog2(DEPTH)+1:0]  outstanding
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int OW = AW + 2;
`ifdef B_DECERR_EN
  localparam int EW = ID_WIDTH + 2;
`else
  localparam int EW = ID_WIDTH + 1;
`endif
  logic [EW-1:0] aw_mem [DEPTH];
  logic          w_mem  [DEPTH];
  logic [PW-1:0] aw_wp, aw_rp, w_wp, w_rp;
  logic [EW-1:0] aw_entry, aw_head;
  logic          aw_empty, w_empty, aw_we, w_we, load, hs, head_slverr;
  logic [1:0]    resp_nxt;
`ifdef B_DECERR_EN
  assign aw_entry = {aw_decerr, aw_slverr, aw_id};
`else
  assign aw_entry = {aw_slverr, aw_id};
`endif
  assign aw_head     = aw_mem[aw_rp[AW-1:0]];
  assign aw_empty    = aw_wp == aw_rp;
  assign w_empty     = w_wp == w_rp;
  assign aw_full     = aw_wp == {~aw_rp[AW], aw_rp[AW-1:0]};
  assign w_full      = w_wp == {~w_rp[AW], w_rp[AW-1:0]};
  assign aw_we       = aw_push && !aw_full;
  assign w_we        = w_push && !w_full;
  assign hs          = BVALID && BREADY;
  assign load        = !aw_empty && !w_empty && (!BVALID || BREADY);
  assign head_slverr = aw_head[ID_WIDTH] | w_mem[w_rp[AW-1:0]];
  always_comb begin
`ifdef B_DECERR_EN
    resp_nxt = aw_head[EW-1] ? 2'b11 : head_slverr ? 2'b10 : 2'b00;
`else
    resp_nxt = head_slverr ? 2'b10 : 2'b00;
`endif
  end
  // Storage needs no reset: entries are only read between valid pointers.
  always_ff @(posedge clk) begin
    if (aw_we) aw_mem[aw_wp[AW-1:0]] <= aw_entry;
    if (w_we) w_mem[w_wp[AW-1:0]] <= w_slverr;
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      aw_wp       <= '0;
      aw_rp       <= '0;
      w_wp        <= '0;
      w_rp        <= '0;
      BVALID      <= 1'b0;
      BID         <= '0;
      BRESP       <= 2'b00;
      outstanding <= '0;
    end else begin
      if (aw_we) aw_wp <= aw_wp + 1'b1;
      if (w_we) w_wp <= w_wp + 1'b1;
      if (load) begin
        aw_rp <= aw_rp + 1'b1;
        w_rp  <= w_rp + 1'b1;
        BID   <= aw_head[ID_WIDTH-1:0];
        BRESP <= resp_nxt;
      end
      BVALID      <= load || (BVALID && !BREADY);
      outstanding <= outstanding + OW'(aw_we) - OW'(hs);
    end
  end
endmodule

// File: tb/tb_b_resp_gen.sv
// tb_b_resp_gen: directed self-checking bench for b_resp_gen.
module tb_b_resp_gen;
  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       aw_push = 1'b0, aw_slverr = 1'b0, w_push = 1'b0, w_slverr = 1'b0, BREADY = 1'b0;
  logic       aw_decerr = 1'b0;
  logic [3:0] aw_id = '0;
  logic       aw_full, w_full, BVALID;
  logic [3:0] BID;
  logic [1:0] BRESP;
  logic [3:0] outstanding;
  int errors = 0;
  int checks = 0;

  b_resp_gen #(.ID_WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .nrst(nrst),
    .aw_push(aw_push), .aw_id(aw_id), .aw_slverr(aw_slverr),
`ifdef B_DECERR_EN
    .aw_decerr(aw_decerr),
`endif
    .aw_full(aw_full), .w_push(w_push), .w_slverr(w_slverr), .w_full(w_full),
    .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (BVALID !== 1'b0) begin errors++; $display("FAIL reset_bvalid: got %0h expected 0", BVALID); end
    checks++; if (BID !== 4'h0) begin errors++; $display("FAIL reset_bid: got %0h expected 0", BID); end
    checks++; if (BRESP !== 2'b00) begin errors++; $display("FAIL reset_bresp: got %0h expected 0", BRESP); end
    checks++; if ({aw_full, w_full} !== 2'b00) begin errors++; $display("FAIL reset_full: got %0b expected 00", {aw_full, w_full}); end
    checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
    #10 nrst = 1'b1;
    step();
  endtask

  task automatic test_single();
    aw_push = 1'b1; aw_id = 4'd3;
    step();
    aw_push = 1'b0;
    checks++; if (outstanding !== 4'd1) begin errors++; $display("FAIL single_out1: got %0d expected 1", outstanding); end
    w_push = 1'b1;
    step();
    w_push = 1'b0; BREADY = 1'b1;
    step();
    checks++; if ({BVALID, BID, BRESP} !== {1'b1, 4'd3, 2'b00}) begin errors++; $display("FAIL single_b: got v=%0b id=%0d resp=%0b expected v=1 id=3 resp=00", BVALID, BID, BRESP); end
    checks++; if (outstanding !== 4'd1) begin errors++; $display("FAIL single_out_b: got %0d expected 1", outstanding); end
    step();
    checks++; if (BVALID !== 1'b0) begin errors++; $display("FAIL single_clear: got %0b expected 0", BVALID); end
    checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL single_out0: got %0d expected 0", outstanding); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ids [3] = '{4'd1, 4'd2, 4'd5};
    w_push = 1'b1;
    repeat (3) step();
    w_push = 1'b0; BREADY = 1'b1;
    aw_push = 1'b1; aw_id = ids[0];
    step();
    for (int i = 0; i < 3; i++) begin
      aw_push = i < 2; aw_id = i < 2 ? ids[i+1] : 4'd0;
      step();
      checks++; if ({BVALID, BID, BRESP} !== {1'b1, ids[i], 2'b00}) begin errors++; $display("FAIL b2b_%0d: got v=%0b id=%0d resp=%0b expected v=1 id=%0d resp=00", i, BVALID, BID, BRESP, ids[i]); end
    end
    step();
    checks++; if ({BVALID, outstanding} !== {1'b0, 4'd0}) begin errors++; $display("FAIL b2b_end: got v=%0b out=%0d expected v=0 out=0", BVALID, outstanding); end
  endtask

  task automatic test_aw_full();
    int n = 0;
    logic [3:0] seen [4];
    BREADY = 1'b0; aw_push = 1'b1;
    for (int i = 0; i < 4; i++) begin aw_id = 4'(4 + i); step(); end
    checks++; if ({aw_full, outstanding} !== {1'b1, 4'd4}) begin errors++; $display("FAIL awfull_set: got full=%0b out=%0d expected full=1 out=4", aw_full, outstanding); end
    aw_id = 4'd9;
    step();
    aw_push = 1'b0;
    checks++; if (outstanding !== 4'd4) begin errors++; $display("FAIL awfull_ignored: got %0d expected 4", outstanding); end
    BREADY = 1'b1; w_push = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 4) w_push = 1'b0;
      step();
      if (BVALID) begin
        if (n < 4) seen[n] = BID;
        n++;
      end
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL awfull_count: got %0d expected 4", n); end
    for (int i = 0; i < 4 && i < n; i++) begin
      checks++; if (seen[i] !== 4'(4 + i)) begin errors++; $display("FAIL awfull_order_%0d: got %0d expected %0d", i, seen[i], 4 + i); end
    end
    checks++; if ({aw_full, outstanding} !== {1'b0, 4'd0}) begin errors++; $display("FAIL awfull_clear: got full=%0b out=%0d expected full=0 out=0", aw_full, outstanding); end
  endtask

  task automatic test_w_full();
    BREADY = 1'b1; w_push = 1'b1;
    repeat (4) step();
    checks++; if (w_full !== 1'b1) begin errors++; $display("FAIL wfull_set: got %0b expected 1", w_full); end
    step();
    w_push = 1'b0; aw_push = 1'b1; aw_id = 4'd0;
    repeat (4) step();
    aw_push = 1'b0;
    repeat (3) step();
    checks++; if ({w_full, outstanding} !== {1'b0, 4'd0}) begin errors++; $display("FAIL wfull_drain: got full=%0b out=%0d expected full=0 out=0", w_full, outstanding); end
    aw_push = 1'b1; aw_id = 4'hA;
    step();
    aw_push = 1'b0;
    repeat (3) step();
    checks++; if ({BVALID, outstanding} !== {1'b0, 4'd1}) begin errors++; $display("FAIL wfull_ignored: got v=%0b out=%0d expected v=0 out=1", BVALID, outstanding); end
    w_push = 1'b1;
    step();
    w_push = 1'b0;
    step();
    checks++; if ({BVALID, BID} !== {1'b1, 4'hA}) begin errors++; $display("FAIL wfull_late_b: got v=%0b id=%0h expected v=1 id=a", BVALID, BID); end
    step();
  endtask

  task automatic test_hold();
    BREADY = 1'b0; aw_push = 1'b1; w_push = 1'b1; aw_id = 4'd2;
    step();
    aw_id = 4'd3; aw_slverr = 1'b1;
    step();
    aw_push = 1'b0; w_push = 1'b0; aw_slverr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({BVALID, BID, BRESP} !== {1'b1, 4'd2, 2'b00}) begin errors++; $display("FAIL hold_%0d: got v=%0b id=%0d resp=%0b expected v=1 id=2 resp=00", i, BVALID, BID, BRESP); end
      step();
    end
    BREADY = 1'b1;
    step();
    checks++; if ({BVALID, BID, BRESP} !== {1'b1, 4'd3, 2'b10}) begin errors++; $display("FAIL hold_next: got v=%0b id=%0d resp=%0b expected v=1 id=3 resp=10", BVALID, BID, BRESP); end
    step();
    checks++; if ({BVALID, outstanding} !== {1'b0, 4'd0}) begin errors++; $display("FAIL hold_end: got v=%0b out=%0d expected v=0 out=0", BVALID, outstanding); end
  endtask

  task automatic test_resp_codes();
`ifdef B_DECERR_EN
    localparam int N = 5;
    logic [2:0] vec [N] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
    logic [1:0] exp [N] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b11};
`else
    localparam int N = 4;
    logic [2:0] vec [N] = '{3'b000, 3'b001, 3'b010, 3'b011};
    logic [1:0] exp [N] = '{2'b00, 2'b10, 2'b10, 2'b10};
`endif
    BREADY = 1'b1;
    for (int i = 0; i < N; i++) begin
      aw_push = 1'b1; w_push = 1'b1; aw_id = 4'(i + 8);
      {aw_decerr, aw_slverr, w_slverr} = vec[i];
      step();
      aw_push = 1'b0; w_push = 1'b0; {aw_decerr, aw_slverr, w_slverr} = 3'b000;
      step();
      checks++; if ({BVALID, BID, BRESP} !== {1'b1, 4'(i + 8), exp[i]}) begin errors++; $display("FAIL resp_%0d: got v=%0b id=%0d resp=%0b expected v=1 id=%0d resp=%0b", i, BVALID, BID, BRESP, i + 8, exp[i]); end
      step();
    end
  endtask

  task automatic test_async_reset();
    int stale = 0;
    BREADY = 1'b0; aw_push = 1'b1; w_push = 1'b1; aw_id = 4'd7;
    repeat (3) step();
    aw_push = 1'b0; w_push = 1'b0;
    step();
    checks++; if ({BVALID, outstanding} !== {1'b1, 4'd3}) begin errors++; $display("FAIL areset_pre: got v=%0b out=%0d expected v=1 out=3", BVALID, outstanding); end
    #2 nrst = 1'b0;
    #1;
    checks++; if ({BVALID, outstanding, aw_full, w_full} !== {1'b1 ^ 1'b1, 4'd0, 2'b00}) begin errors++; $display("FAIL areset_now: got v=%0b out=%0d expected v=0 out=0", BVALID, outstanding); end
    #3 nrst = 1'b1;
    BREADY = 1'b1;
    repeat (6) begin step(); if (BVALID) stale++; end
    checks++; if (stale !== 0) begin errors++; $display("FAIL areset_stale: got %0d responses expected 0", stale); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_aw_full();
    test_w_full();
    test_hold();
    test_resp_codes();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/b_resp_gen.md
Name: b_resp_gen

Overview:
- Slave-side AXI write-response generator; the producing end of the B channel.
- Pairs each accepted AW address with its W last beat and issues BID/BRESP on a registered BVALID/BREADY interface.
- Output feeds the crossbar B path, e.g. the push side of the B-channel FIFO.
- Single clock domain; tolerates W data arriving before AW.

Parameters:
- ID_WIDTH, 4, width of AWID/BID.
- DEPTH, 4, entries in each of the AW and W-last tracking queues; power of two, at least 2.

Ports:
- clk  input  1  clock
- nrst  input  1  asynchronous active-low reset
- aw_push  input  1  an AW handshake completed this cycle
- aw_id  input  ID_WIDTH  AWID of that transaction
- aw_slverr  input  1  address-phase error for that transaction
- aw_full  output  1  AW queue holds DEPTH entries; upstream must not assert aw_push
- w_push  input  1  a W beat with WLAST completed this cycle
- w_slverr  input  1  data-phase error accumulated over that burst
- w_full  output  1  W queue holds DEPTH entries; upstream must not assert w_push
- BVALID  output  1  response valid
- BREADY  input  1  master ready
- BID  output  ID_WIDTH  response ID
- BRESP  output  2  response code
- outstanding  output  $clog2(DEPTH)+2  responses not yet handshaken (AW queue count plus BVALID)

Behaviour:
- Reset (nrst low, asynchronous): both queues empty; all pointers and counts are 0.
- Reset values: BVALID=0, BID=0, BRESP=2'b00, aw_full=0, w_full=0, outstanding=0.
- Reset mid-transaction discards all pending entries. No B is issued for them.
- AW queue:
  - Circular buffer of {id, err}.
  - Read/write pointers are $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty across wrap.
  - aw_full is decoded from registered pointers only.
- W queue: same structure, storing {err}.
- Push while full: the push is ignored and state is unchanged, even if a pop occurs in the same cycle. Upstream ready is derived from the full flags.
- Simultaneous push and pop on a non-full queue: both take effect; the count is unchanged.
- Output register load condition: AW queue non-empty AND W queue non-empty AND (BVALID==0 OR BREADY==1).
- When the load condition holds:
  - Pop both queues.
  - Next-cycle BVALID=1, BID=AW head id.
  - BRESP = 2'b10 (SLVERR) if AW head err OR W head err, else 2'b00 (OKAY).
- When BVALID && BREADY and no load: BVALID clears next cycle. BID/BRESP hold their last values.
- Handshake rules:
  - While BVALID=1 and BREADY=0, BVALID/BID/BRESP are stable.
  - BVALID never depends combinationally on BREADY.
- Latency: the cycle after both the AW entry and the W entry are present (i.e. the cycle after the later push), BVALID=1. Minimum 1 cycle from the later push.
- Throughput: one response per cycle under continuous BREADY=1 with both queues non-empty.
- Ordering: responses are strictly in AW acceptance order. W lasts are paired in arrival order (no write interleaving).
- W before AW: the W entry waits in the W queue; B issues 1 cycle after the matching aw_push.
- outstanding:
  - Increments on an accepted aw_push.
  - Decrements on a BVALID&&BREADY handshake.
  - Both in the same cycle leaves it unchanged.
  - Never wraps, given the full-flag discipline.

Optional Feature:
- Macro: B_DECERR_EN.
- When defined:
  - Adds input port aw_decerr (1 bit), stored as an extra AW queue bit.
  - BRESP=2'b11 (DECERR) when the head has decerr set; this takes priority over SLVERR.
- When undefined: the port and storage bit are absent; BRESP is only 2'b00 or 2'b10.

Test Plan:
- Reset then aw_push id=3, next cycle w_push → one cycle after w_push, BVALID=1, BID=3, BRESP=00; with BREADY=1, BVALID=0 the following cycle; outstanding 1→0.
- Three w_push back-to-back, then aw_push ids 1,2,5 on consecutive cycles with BREADY=1 → BIDs 1,2,5 on three consecutive cycles, all OKAY.
- Fill AW queue with 4 entries → aw_full=1; a 5th aw_push is ignored (outstanding stays 4); drain 4 responses with BREADY=1 → aw_full=0.
- BREADY=0 with a response pending → BVALID/BID/BRESP held stable for 5 cycles; raise BREADY → same-cycle handshake; a queued next response appears the next cycle.
- aw_slverr=0 with w_slverr=1 → BRESP=10; with B_DECERR_EN defined, aw_decerr=1 plus w_slverr=1 → BRESP=11.
- Assert nrst low while 2 responses are queued and BVALID=1 → BVALID=0 immediately, outstanding=0; no stale B after reset release.
